// File: rtl/fp_pkg.sv
// Shared state encoding, flag positions and IEEE field helpers for the sequential FP adder.
// Helpers take words zero-extended to 64 bits so any format up to double precision fits.
package fp_pkg;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_e;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] q;
    q = ((64'd1 << exp_w) - 64'd1) << man_w;
    q = q | (64'd1 << (man_w - 1));
    return q;
  endfunction

  function automatic logic [63:0] exp_field(input logic [63:0] word, input int exp_w,
                                            input int man_w);
    return (word >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] man_field(input logic [63:0] word, input int man_w);
    return word & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic is_inf(input logic [63:0] word, input int exp_w, input int man_w);
    return (exp_field(word, exp_w, man_w) == ((64'd1 << exp_w) - 64'd1)) &&
           (man_field(word, man_w) == 64'd0);
  endfunction

  function automatic logic is_nan(input logic [63:0] word, input int exp_w, input int man_w);
    return (exp_field(word, exp_w, man_w) == ((64'd1 << exp_w) - 64'd1)) &&
           (man_field(word, man_w) != 64'd0);
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of an FP word into sign, raw exponent, significand and class bits.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       sig_o,
  output logic                 zero_o,
  output logic                 denorm_o,
  output logic                 inf_o,
  output logic                 nan_o,
  output logic                 snan_o
);

  logic [EXP_W-1:0] exp_raw;
  logic [MAN_W-1:0] man;
  logic             exp_nz;

  assign exp_raw  = op_i[EXP_W+MAN_W-1:MAN_W];
  assign man      = op_i[MAN_W-1:0];
  assign exp_nz   = |exp_raw;

  assign sign_o   = op_i[EXP_W+MAN_W];
  assign exp_o    = exp_raw;
  assign sig_o    = {exp_nz, man};
  assign zero_o   = !exp_nz && (man == '0);
  assign denorm_o = !exp_nz && (man != '0);
  assign inf_o    = is_inf(64'(op_i), EXP_W, MAN_W);
  assign nan_o    = is_nan(64'(op_i), EXP_W, MAN_W);
  // Quiet bit is the mantissa MSB; a NaN without it is signalling.
  assign snan_o   = nan_o && !man[MAN_W-1];

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP adder/subtractor: ALIGN, ADD, NORM (one shift per cycle), ROUND (RNE), DONE.
// NaN/inf operands are resolved at capture and go straight to DONE.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int FW = MAN_W + 4;  // hidden + mantissa + guard/round/sticky
  localparam int MW = MAN_W + 5;  // FW plus carry
  localparam int XW = EXP_W + 1;

  state_e           state_q, state_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [MAN_W:0]   ma_q, ma_d, mb_q, mb_d;
  logic             sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [XW-1:0]    exp_q, exp_d;
  logic [MW-1:0]    m_q, m_d;
  logic [FW-1:0]    y_q, y_d;
  logic [W-1:0]     res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic             ua_sign, ua_zero, ua_den, ua_inf, ua_nan, ua_snan;
  logic             ub_sign, ub_zero, ub_den, ub_inf, ub_nan, ub_snan;
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MAN_W:0]   ua_sig, ub_sig;
  logic             sb_eff;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op_i(a), .sign_o(ua_sign), .exp_o(ua_exp), .sig_o(ua_sig), .zero_o(ua_zero),
    .denorm_o(ua_den), .inf_o(ua_inf), .nan_o(ua_nan), .snan_o(ua_snan)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op_i(b), .sign_o(ub_sign), .exp_o(ub_exp), .sig_o(ub_sig), .zero_o(ub_zero),
    .denorm_o(ub_den), .inf_o(ub_inf), .nan_o(ub_nan), .snan_o(ub_snan)
  );

  assign sb_eff = ub_sign ^ sub;

  logic             a_big;
  logic [EXP_W-1:0] ex, ey, diff;
  logic [MAN_W:0]   sx_sig, sy_sig;
  logic [2*FW-1:0]  y_wide;
  logic [FW-1:0]    y_al;

  // Low half of y_wide catches every bit shifted past the sticky position.
  always_comb begin
    a_big  = {ea_q, ma_q} >= {eb_q, mb_q};
    ex     = a_big ? ea_q : eb_q;
    ey     = a_big ? eb_q : ea_q;
    sx_sig = a_big ? ma_q : mb_q;
    sy_sig = a_big ? mb_q : ma_q;
    diff   = ex - ey;
    y_wide = {sy_sig, 3'b000, {FW{1'b0}}} >> diff;
    if (32'(diff) >= 32'(MAN_W + 3)) begin
      y_al = {{(FW-1){1'b0}}, |sy_sig};
    end else begin
      y_al = {y_wide[2*FW-1:FW+1], y_wide[FW] | (|y_wide[FW-1:0])};
    end
  end

  logic             rnd_up, inexact, hidden;
  logic [MAN_W+1:0] sig_r;
  logic [XW-1:0]    exp_r;

  always_comb begin
    inexact = |m_q[2:0];
    rnd_up  = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    sig_r   = {1'b0, m_q[MW-2:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    exp_r   = sig_r[MAN_W+1] ? exp_q + XW'(1) : exp_q;
    hidden  = sig_r[MAN_W+1] | sig_r[MAN_W];
  end

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    exp_d     = exp_q;
    m_d       = m_q;
    y_d       = y_q;
    res_d     = res_q;
    flags_d   = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = ua_sign;
          sb_d    = sb_eff;
          ea_d    = (ua_zero | ua_den) ? EXP_W'(1) : ua_exp;
          eb_d    = (ub_zero | ub_den) ? EXP_W'(1) : ub_exp;
          ma_d    = ua_sig;
          mb_d    = ub_sig;
          flags_d = '0;
          if (ua_nan | ub_nan) begin
            res_d                 = W'(qnan(EXP_W, MAN_W));
            flags_d[FLAG_INVALID] = ua_snan | ub_snan;
            state_d               = DONE;
          end else if (ua_inf && ub_inf && (ua_sign != sb_eff)) begin
            res_d                 = W'(qnan(EXP_W, MAN_W));
            flags_d[FLAG_INVALID] = 1'b1;
            state_d               = DONE;
          end else if (ua_inf) begin
            res_d   = {ua_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            state_d = DONE;
          end else if (ub_inf) begin
            res_d   = {sb_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            state_d = DONE;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        sign_d    = a_big ? sa_q : sb_q;
        eff_sub_d = sa_q ^ sb_q;
        exp_d     = {1'b0, ex};
        m_d       = {1'b0, sx_sig, 3'b000};
        y_d       = y_al;
        state_d   = ADD;
      end
      ADD: begin
        m_d     = eff_sub_q ? m_q - {1'b0, y_q} : m_q + {1'b0, y_q};
        state_d = NORM;
      end
      NORM: begin
        if (m_q == '0) begin
          sign_d  = eff_sub_q ? 1'b0 : sign_q;
          state_d = ROUND;
        end else if (m_q[MW-1]) begin
          m_d     = {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
          exp_d   = exp_q + XW'(1);
          state_d = ROUND;
        end else if (!m_q[MW-2] && (exp_q > XW'(1))) begin
          m_d   = m_q << 1;
          exp_d = exp_q - XW'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        flags_d = '0;
        if (hidden && (exp_r >= {1'b0, {EXP_W{1'b1}}})) begin
          res_d                  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d[FLAG_OVERFLOW] = 1'b1;
          flags_d[FLAG_INEXACT]  = 1'b1;
        end else if (hidden) begin
          res_d                 = {sign_q, exp_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
          flags_d[FLAG_INEXACT] = inexact;
        end else begin
          res_d                   = {sign_q, {EXP_W{1'b0}}, sig_r[MAN_W-1:0]};
          flags_d[FLAG_UNDERFLOW] = inexact;
          flags_d[FLAG_INEXACT]   = inexact;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      m_q       <= '0;
      y_q       <= '0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      exp_q     <= exp_d;
      m_q       <= m_d;
      y_q       <= y_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign flags     = flags_q;

endmodule
